seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 27 ++
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
  localparam int ITER  = 8;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DVS_W-1:0] rem,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] dvs,
  output logic [DVS_W-1:0] rem_next,
  output logic             q_bit
);

  logic [DVS_W:0] trial;
  logic [DVS_W:0] diff;

  always_comb begin
    trial = {rem, bit_in};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) begin
      rem_next = diff[DVS_W-1:0];
      q_bit    = 1'b1;
    end else begin
      rem_next = trial[DVS_W-1:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// 8/4 unsigned sequential restoring divider, one quotient bit per clock.
// Optional divide-by-zero shortcut: SEQ_DIVIDER_DIVZERO_DETECT_EN.
module seq_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] dvd;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] rem;
  logic [DVD_W-1:0] quo;

  logic [DVS_W-1:0] rem_next;
  logic             q_bit;
  logic [DVD_W-1:0] quo_next;

`ifdef SEQ_DIVIDER_DIVZERO_DETECT_EN
  logic zdiv;
`endif

  div_step u_step (
    .rem      (rem),
    .bit_in   (dvd[DVD_W-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_next = {quo[DVD_W-2:0], q_bit};

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef SEQ_DIVIDER_DIVZERO_DETECT_EN
          state_next = (divisor == '0) ? DONE : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Normal results load on the final RUN edge so done lands one cycle
  // into DONE; the zero-divisor shortcut loads from inside DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_DIVZERO_DETECT_EN
      zdiv      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd       <= dividend;
            dvs       <= divisor;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            busy      <= 1'b1;
`ifdef SEQ_DIVIDER_DIVZERO_DETECT_EN
            zdiv      <= (divisor == '0);
`endif
          end
        end
        RUN: begin
          dvd <= {dvd[DVD_W-2:0], 1'b0};
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            quotient  <= quo_next;
            remainder <= rem_next;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
`ifdef SEQ_DIVIDER_DIVZERO_DETECT_EN
          if (zdiv) begin
            quotient  <= '1;
            remainder <= dvd[DVS_W-1:0];
            dbz       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expectations,
// a negedge monitor pops and checks on every done pulse.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // cyc at a negedge is the index of the edge just taken; done seen
  // after edge k+8 is cycle k+9 when start was accepted at edge k.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at edge %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("dbz", int'(dbz), int'(e.z));
        chk("done_edge", cyc, e.at);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] q, input logic [3:0] r,
                       input logic z, input int lat, input bit push);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{q, r, z, cyc + lat});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(dbz), 0);
    rst = 1'b0;

    issue(8'd91, 4'd13, 8'd7, 4'd0, 1'b0, 8, 1'b1);
    drain();
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 1'b1);
    drain();
    issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8, 1'b1);
    drain();
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, 1'b1);
    drain();
    issue(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8, 1'b1);
    drain();

`ifdef SEQ_DIVIDER_DIVZERO_DETECT_EN
    issue(8'h37, 4'd0, 8'hFF, 4'd7, 1'b1, 1, 1'b1);
`else
    issue(8'h37, 4'd0, 8'hFF, 4'd7, 1'b0, 8, 1'b1);
`endif
    drain();

    // A start pulse mid-operation must not disturb the result.
    issue(8'd91, 4'd13, 8'd7, 4'd0, 1'b0, 8, 1'b1);
    repeat (3) @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    // Reset at k+5 aborts; no done may follow.
    issue(8'd200, 4'd7, 8'd0, 4'd0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dbz", int'(dbz), 0);
    repeat (12) @(negedge clk);
    issue(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, 1'b1);
    drain();

    // start held: accepts at edges k and k+10.
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{8'd10, 4'd0, 1'b0, cyc + 8});
    sb.push_back('{8'd10, 4'd0, 1'b0, cyc + 18});
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
